// File: rtl/sys_array_pkg.sv
// sys_array_pkg: shared types and constants for the systolic-array result drain.
package sys_array_pkg;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ARRAY_W = 4;
   localparam int DEF_ACC_WIDTH = 2*DEF_DATA_WIDTH+4;
   localparam int DEF_IDX_W = $clog2(DEF_ARRAY_W*DEF_ARRAY_W);
   typedef logic [2*DEF_DATA_WIDTH-1:0] res_elem_t;
   typedef logic [DEF_ACC_WIDTH-1:0] acc_elem_t;
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
   function automatic int idx_width(int aw);
      return (aw*aw > 1) ? $clog2(aw*aw) : 1;
   endfunction
endpackage

// File: rtl/sys_array_acc_buf.sv
// sys_array_acc_buf: ARRAY_W x ARRAY_W result register file with load/add/clear and carry-out.
// Adders exist only when SYS_ARRAY_TILE_ACC_EN is defined.
module sys_array_acc_buf #(
   parameter int ARRAY_W = 4,
   parameter int IN_W = 16,
   parameter int BUF_W = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clear,
   input  logic load,
   input  logic add,
   input  logic [0:ARRAY_W-1][0:ARRAY_W-1][IN_W-1:0] din,
   output logic [0:ARRAY_W-1][0:ARRAY_W-1][BUF_W-1:0] q,
   output logic [0:ARRAY_W-1][0:ARRAY_W-1][BUF_W-1:0] nxt,
   output logic carry
);
`ifdef SYS_ARRAY_TILE_ACC_EN
   logic [0:ARRAY_W-1][0:ARRAY_W-1][BUF_W:0] sum;
   for (genvar r = 0; r < ARRAY_W; r++) begin : g_row
      for (genvar c = 0; c < ARRAY_W; c++) begin : g_col
         assign sum[r][c] = {1'b0, q[r][c]} + (BUF_W+1)'(din[r][c]);
      end
   end
`else
   logic unused_add;
   assign unused_add = add;
`endif
   always_comb begin
      nxt = q;
      carry = 1'b0;
      for (int i = 0; i < ARRAY_W; i++) begin
         for (int j = 0; j < ARRAY_W; j++) begin
`ifdef SYS_ARRAY_TILE_ACC_EN
            nxt[i][j] = clear ? '0 : load ? BUF_W'(din[i][j]) : add ? sum[i][j][BUF_W-1:0] : q[i][j];
            carry = carry | (add & sum[i][j][BUF_W]);
`else
            nxt[i][j] = clear ? '0 : load ? BUF_W'(din[i][j]) : q[i][j];
`endif
         end
      end
   end
   always_ff @(posedge clk) begin
      if (!reset_n) q <= '0;
      else q <= nxt;
   end
endmodule

// File: rtl/sys_array_result_drain.sv
// sys_array_result_drain: captures a W x W result matrix and streams it row-major over valid/ready.
// SYS_ARRAY_TILE_ACC_EN adds K-tile accumulation (ACCUM state, ACC_WIDTH buffer, acc_ovf).
module sys_array_result_drain
   import sys_array_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ARRAY_W = DEF_ARRAY_W,
   parameter int ACC_WIDTH = 2*DATA_WIDTH+4,
`ifdef SYS_ARRAY_TILE_ACC_EN
   localparam int OUT_W = ACC_WIDTH
`else
   localparam int OUT_W = 2*DATA_WIDTH
`endif
) (
   input  logic clk,
   input  logic reset_n,
   input  logic res_valid,
   input  logic [0:ARRAY_W-1][0:ARRAY_W-1][2*DATA_WIDTH-1:0] res_data,
   input  logic tile_last,
   output logic busy,
   output logic m_valid,
   output logic [OUT_W-1:0] m_data,
   output logic m_last,
   input  logic m_ready,
   output logic err_drop,
   output logic acc_ovf
);
   localparam int N = ARRAY_W*ARRAY_W;
   localparam int IW = idx_width(ARRAY_W);
   localparam int RW = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1;
   state_t state;
   logic [IW-1:0] idx, idx_n;
   logic [RW-1:0] row, col;
   logic hs, last_hs, take, drop, load, add, to_drain, clear, carry;
   logic [0:ARRAY_W-1][0:ARRAY_W-1][OUT_W-1:0] q, nxt;
   assign hs = m_valid & m_ready;
   assign last_hs = hs & m_last;
   // the final handshake frees the buffer in the same cycle, so a strobe there is legal
   assign take = res_valid & ((state != DRAIN) | last_hs);
   assign drop = res_valid & (state == DRAIN) & ~last_hs;
   assign clear = last_hs & ~res_valid;
`ifdef SYS_ARRAY_TILE_ACC_EN
   assign load = take & (state != ACCUM);
   assign add = take & (state == ACCUM);
   assign to_drain = take & tile_last;
`else
   logic unused_tile_last;
   localparam int unused_acc_w = ACC_WIDTH;
   assign unused_tile_last = tile_last;
   assign load = take;
   assign add = 1'b0;
   assign to_drain = take;
`endif
   assign idx_n = idx + 1'b1;
   assign row = RW'(idx_n / IW'(ARRAY_W));
   assign col = RW'(idx_n % IW'(ARRAY_W));
   sys_array_acc_buf #(
      .ARRAY_W(ARRAY_W),
      .IN_W(2*DATA_WIDTH),
      .BUF_W(OUT_W)
   ) u_buf (
      .clk(clk),
      .reset_n(reset_n),
      .clear(clear),
      .load(load),
      .add(add),
      .din(res_data),
      .q(q),
      .nxt(nxt),
      .carry(carry)
   );
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= IDLE;
         idx <= '0;
         m_valid <= 1'b0;
         m_data <= '0;
         m_last <= 1'b0;
         busy <= 1'b0;
         err_drop <= 1'b0;
         acc_ovf <= 1'b0;
      end else begin
         err_drop <= err_drop | drop;
         acc_ovf <= acc_ovf | carry;
         if (take) begin
            idx <= '0;
            state <= to_drain ? DRAIN : ACCUM;
            m_valid <= to_drain;
            busy <= to_drain;
            m_data <= to_drain ? nxt[0][0] : '0;
            m_last <= to_drain && (N == 1);
         end else if (hs) begin
            idx <= m_last ? '0 : idx_n;
            state <= m_last ? IDLE : DRAIN;
            m_valid <= ~m_last;
            busy <= ~m_last;
            m_data <= m_last ? '0 : q[row][col];
            m_last <= ~m_last && (idx_n == IW'(N-1));
         end
      end
   end
endmodule
